code_lock_param: RTL and testbench
==================================

# code_lock_param

Parametrised digit-sequence lock controller with a synchronised keypad strobe, a configurable error budget, a timed lockout, runtime code reprogramming and a 7-segment status/digit display. It sits between the keypad/switch front end (`numero`, `insere`) and the board LEDs and 7-segment display. It generalises the fixed 6-digit, one-warning, permanent-fail lock to arbitrary code length, error count and lockout duration.

## Interface
- `DIGITS`, 6: code length in digits, ≥2.
- `MAX_ERRORS`, 2: wrong entries that trigger lockout, ≥1.
- `LOCKOUT_CYCLES`, 8: lockout duration in clk cycles; 0 means lockout holds until reset.
- `CODE`, 24'h590281: reset code, 4*DIGITS bits, BCD, first digit in the MS nibble.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `insere`  in  1  asynchronous digit-enter button, level.
- `numero`  in  4  digit value, BCD; values above 9 are invalid.
- `relock`  in  1  synchronous pulse; returns OPEN to ENTRY.
- `prog_en`  in  1  level; enables code programming while OPEN.
- `unlocked`  out  1  high in OPEN.
- `warn`  out  1  high while the error count is >0 (ENTRY only).
- `locked_out`  out  1  high in LOCKOUT.
- `prog_done`  out  1  one-cycle pulse when a new code is committed.
- `digit_idx`  out  $clog2(DIGITS)  next expected digit position.
- `seg`  out  7  {G,F,E,D,C,B,A}, active-low.

## Operation
- `insere` passes through a 2-FF synchroniser and a rising-edge detector, producing a one-cycle `stb`. Only `stb` is acted on. A held level yields exactly one `stb`.
- Internal registers:
  - `code_reg`, loaded from `CODE` on reset.
  - `idx`, the expected digit position.
  - `err_cnt`, the error count.
  - `last_dig`, the last digit accepted.
  - Lockout timer.
  - `prog_idx` and a shadow code register.
- States: ENTRY, OPEN, LOCKOUT. Reset enters ENTRY.
- ENTRY, on `stb`:
  - `last_dig` is loaded with `numero`.
  - Match (`numero == code_reg[idx]`): `idx`+1. If `idx == DIGITS-1`, go to OPEN, clear `idx` and `err_cnt`.
  - Mismatch, including `numero` > 9: `idx` is held, so the same digit is retried. If `err_cnt+1 == MAX_ERRORS`, go to LOCKOUT, clear `idx` and `err_cnt`, and load the timer with `LOCKOUT_CYCLES`. Otherwise `err_cnt`+1.
- LOCKOUT:
  - `stb`, `relock` and `prog_en` are ignored.
  - The timer decrements each cycle. At 1, the next state is ENTRY.
  - With `LOCKOUT_CYCLES == 0`, LOCKOUT is exited only by reset.
- OPEN:
  - `relock` goes to ENTRY. `relock` wins over a simultaneous `stb`, and any partial programming is discarded.
  - With `prog_en` high, `stb` with `numero` ≤ 9 writes `shadow[prog_idx]` and advances `prog_idx`. An invalid digit is ignored.
  - After the `DIGITS`-th write: `code_reg` ← shadow, `prog_done` pulses, `prog_idx` ← 0, and the lock stays OPEN.
  - `prog_en` low clears `prog_idx`, discarding a partial code.
- `stb` in OPEN with `prog_en` low has no effect.
- Display:
  - ENTRY: blank (7'h7F) after reset until the first `stb`, then `last_dig` decoded. Digits 0–9 use standard patterns (0 = 7'h40, 5 = 7'h12, 9 = 7'h10). Values >9 show "-" (7'h3F).
  - OPEN: "U" (7'h41).
  - LOCKOUT: "E" (7'h06).
  - While programming, ENTRY-style decode of the last programmed digit.

## Timing
- Reset values: `unlocked`=0, `warn`=0, `locked_out`=0, `prog_done`=0, `digit_idx`=0, `seg`=7'h7F.
- `stb` is high in the cycle after the third rising clk edge that samples `insere` high. Minimum `insere` low and high widths are 3 cycles each.
- All outputs are registered and update on the clk edge where `stb` (or `relock`, or timer expiry) is sampled high.
- Latency from `insere` rise to output change is 4 clk edges.
- Lockout: `locked_out` is high for exactly `LOCKOUT_CYCLES` cycles. `stb` or `relock` arriving in the exit cycle is ignored.
- `reset` wins over all events in the same cycle. Reset mid-lockout or mid-programming restores `code_reg` to `CODE`.

## Test plan
- Enter 5,9,0,2,8,1 → `digit_idx` steps 1..5. After the last digit: `unlocked`=1, `seg`=7'h41, `warn`=0.
- Enter 5,3,9,0,2,8,1 → `warn`=1 after 3 with `digit_idx`=1 held, then `unlocked`=1 after 1.
- Enter 5,3,7 → `locked_out`=1 and `seg`=7'h06 for exactly 8 cycles, with `stb`s during lockout ignored. Then ENTRY, `digit_idx`=0, `warn`=0.
- With `LOCKOUT_CYCLES`=0: enter 3,3 → `locked_out` stays 1 for 1000 cycles, then `reset` → ENTRY.
- Unlock, set `prog_en`=1, enter 1,2,3,4,5,6 → `prog_done` pulses once. Then `relock`; 5,9,0,2,8,1 fails and 1,2,3,4,5,6 unlocks.
- Hold `insere` high for 50 cycles with `numero`=5 → exactly one digit accepted. `reset` asserted mid-entry → all outputs at reset values the next cycle.

Source files
------------

// File: rtl/code_lock_param.sv
`default_nettype none
// ============================================================================
// Module   : code_lock_param
// Purpose  : Keypad digit-sequence lock with error budget, timed lockout,
//            runtime code reprogramming and a 7-segment status display.
// Revision : 1.0
// ============================================================================
module code_lock_param #(
  parameter int                  DIGITS         = 6,
  parameter int                  MAX_ERRORS     = 2,
  parameter int                  LOCKOUT_CYCLES = 8,
  parameter logic [4*DIGITS-1:0] CODE           = 24'h590281
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      insere,
  input  logic [3:0]                numero,
  input  logic                      relock,
  input  logic                      prog_en,
  output logic                      unlocked,
  output logic                      warn,
  output logic                      locked_out,
  output logic                      prog_done,
  output logic [$clog2(DIGITS)-1:0] digit_idx,
  output logic [6:0]                seg
);

  localparam int c_IDX_W = $clog2(DIGITS);
  localparam int c_ERR_W = (MAX_ERRORS < 2) ? 1 : $clog2(MAX_ERRORS);
  localparam int c_TMR_W = (LOCKOUT_CYCLES < 2) ? 1 : $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DIGITS - 1);
  localparam logic [c_ERR_W-1:0] c_LAST_ERR = c_ERR_W'(MAX_ERRORS - 1);
  localparam logic [c_TMR_W-1:0] c_TMR_LOAD = c_TMR_W'(LOCKOUT_CYCLES);
  localparam logic [c_TMR_W-1:0] c_TMR_ONE  = c_TMR_W'(1);

  localparam logic [6:0] c_SEG_BLANK = 7'h7F;
  localparam logic [6:0] c_SEG_OPEN  = 7'h41;
  localparam logic [6:0] c_SEG_LOCK  = 7'h06;

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_OPEN    = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_t;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h3F;
    endcase
  endfunction

  // insere is asynchronous: two-stage synchroniser, then a registered rising-edge pulse
  logic r_sync1, r_sync2, r_sync3, r_stb;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_stb   <= 1'b0;
    end else begin
      r_sync1 <= insere;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_stb   <= r_sync2 & ~r_sync3;
    end
  end

  state_t                r_state,    w_state_nxt;
  logic [4*DIGITS-1:0]   r_code,     w_code_nxt;
  logic [4*DIGITS-1:0]   r_shadow,   w_shadow_nxt;
  logic [c_IDX_W-1:0]    r_idx,      w_idx_nxt;
  logic [c_ERR_W-1:0]    r_err,      w_err_nxt;
  logic [3:0]            r_last_dig, w_last_dig_nxt;
  logic                  r_shown,    w_shown_nxt;
  logic [c_TMR_W-1:0]    r_timer,    w_timer_nxt;
  logic [c_IDX_W-1:0]    r_prog_idx, w_prog_idx_nxt;
  logic [3:0]            r_prog_dig, w_prog_dig_nxt;
  logic                  w_done_nxt;
  logic [3:0]            w_exp_dig;
  logic                  w_valid;
  logic [6:0]            w_seg_nxt;

  assign w_valid = (numero <= 4'd9);

  // Digit 0 lives in the most-significant nibble
  always_comb begin
    w_exp_dig = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (i == int'(r_idx)) w_exp_dig = r_code[4*(DIGITS-1-i) +: 4];
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_code_nxt     = r_code;
    w_shadow_nxt   = r_shadow;
    w_idx_nxt      = r_idx;
    w_err_nxt      = r_err;
    w_last_dig_nxt = r_last_dig;
    w_shown_nxt    = r_shown;
    w_timer_nxt    = r_timer;
    w_prog_idx_nxt = r_prog_idx;
    w_prog_dig_nxt = r_prog_dig;
    w_done_nxt     = 1'b0;

    case (r_state)
      ST_ENTRY: begin
        if (r_stb) begin
          w_last_dig_nxt = numero;
          w_shown_nxt    = 1'b1;
          if (w_valid && (numero == w_exp_dig)) begin
            if (r_idx == c_LAST_IDX) begin
              w_state_nxt = ST_OPEN;
              w_idx_nxt   = '0;
              w_err_nxt   = '0;
            end else begin
              w_idx_nxt = r_idx + 1'b1;
            end
          end else if (r_err == c_LAST_ERR) begin
            w_state_nxt = ST_LOCKOUT;
            w_idx_nxt   = '0;
            w_err_nxt   = '0;
            w_timer_nxt = c_TMR_LOAD;
          end else begin
            w_err_nxt = r_err + 1'b1;
          end
        end
      end

      ST_LOCKOUT: begin
        // A zero load never reaches one, so the lockout then holds until reset
        if (r_timer == c_TMR_ONE) begin
          w_state_nxt = ST_ENTRY;
          w_timer_nxt = '0;
        end else if (r_timer != '0) begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end

      ST_OPEN: begin
        if (relock) begin
          w_state_nxt    = ST_ENTRY;
          w_prog_idx_nxt = '0;
        end else if (!prog_en) begin
          w_prog_idx_nxt = '0;
        end else if (r_stb && w_valid) begin
          for (int i = 0; i < DIGITS; i++) begin
            if (i == int'(r_prog_idx)) w_shadow_nxt[4*(DIGITS-1-i) +: 4] = numero;
          end
          w_prog_dig_nxt = numero;
          if (r_prog_idx == c_LAST_IDX) begin
            w_code_nxt     = w_shadow_nxt;
            w_done_nxt     = 1'b1;
            w_prog_idx_nxt = '0;
          end else begin
            w_prog_idx_nxt = r_prog_idx + 1'b1;
          end
        end
      end

      default: w_state_nxt = ST_ENTRY;
    endcase
  end

  always_comb begin
    w_seg_nxt = c_SEG_BLANK;
    case (w_state_nxt)
      ST_ENTRY:   w_seg_nxt = w_shown_nxt ? seg7(w_last_dig_nxt) : c_SEG_BLANK;
      ST_OPEN:    w_seg_nxt = (w_prog_idx_nxt != '0) ? seg7(w_prog_dig_nxt) : c_SEG_OPEN;
      ST_LOCKOUT: w_seg_nxt = c_SEG_LOCK;
      default:    w_seg_nxt = c_SEG_BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_ENTRY;
      r_code     <= CODE;
      r_shadow   <= CODE;
      r_idx      <= '0;
      r_err      <= '0;
      r_last_dig <= 4'd0;
      r_shown    <= 1'b0;
      r_timer    <= '0;
      r_prog_idx <= '0;
      r_prog_dig <= 4'd0;
      unlocked   <= 1'b0;
      warn       <= 1'b0;
      locked_out <= 1'b0;
      prog_done  <= 1'b0;
      digit_idx  <= '0;
      seg        <= c_SEG_BLANK;
    end else begin
      r_state    <= w_state_nxt;
      r_code     <= w_code_nxt;
      r_shadow   <= w_shadow_nxt;
      r_idx      <= w_idx_nxt;
      r_err      <= w_err_nxt;
      r_last_dig <= w_last_dig_nxt;
      r_shown    <= w_shown_nxt;
      r_timer    <= w_timer_nxt;
      r_prog_idx <= w_prog_idx_nxt;
      r_prog_dig <= w_prog_dig_nxt;
      unlocked   <= (w_state_nxt == ST_OPEN);
      warn       <= (w_state_nxt == ST_ENTRY) && (w_err_nxt != '0);
      locked_out <= (w_state_nxt == ST_LOCKOUT);
      prog_done  <= w_done_nxt;
      digit_idx  <= w_idx_nxt;
      seg        <= w_seg_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_code_lock_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_code_lock_param
// Purpose  : Self-checking bench; two lock instances (timed and permanent
//            lockout) compared every cycle against a digit-level model.
// Revision : 1.0
// ============================================================================
module tb_code_lock_param;

  localparam int N_DIG = 6;
  localparam int N_ERR = 2;

  typedef enum int {M_ENTRY, M_OPEN, M_LOCK} mmode_t;

  logic       clk;
  logic       reset;
  logic       insere;
  logic [3:0] numero;
  logic       relock;
  logic       prog_en;

  logic       unlocked0, warn0, locked_out0, prog_done0;
  logic [2:0] digit_idx0;
  logic [6:0] seg0;
  logic       unlocked1, warn1, locked_out1, prog_done1;
  logic [2:0] digit_idx1;
  logic [6:0] seg1;

  code_lock_param u_dut0 (
    .clk        (clk),
    .reset      (reset),
    .insere     (insere),
    .numero     (numero),
    .relock     (relock),
    .prog_en    (prog_en),
    .unlocked   (unlocked0),
    .warn       (warn0),
    .locked_out (locked_out0),
    .prog_done  (prog_done0),
    .digit_idx  (digit_idx0),
    .seg        (seg0)
  );

  code_lock_param #(.LOCKOUT_CYCLES(0)) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .insere     (insere),
    .numero     (numero),
    .relock     (relock),
    .prog_en    (prog_en),
    .unlocked   (unlocked1),
    .warn       (warn1),
    .locked_out (locked_out1),
    .prog_done  (prog_done1),
    .digit_idx  (digit_idx1),
    .seg        (seg1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int lo_count = 0;
  int pd_count = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: one entry per instance, digit-level view of the lock
  mmode_t m_mode [2];
  int     m_pos  [2];
  int     m_errs [2];
  int     m_left [2];
  int     m_shown[2];
  int     m_plen [2];
  bit     m_done [2];
  int     m_code [2][N_DIG];
  int     m_pbuf [2][N_DIG];
  int     ref_code[N_DIG] = '{5, 9, 0, 2, 8, 1};
  logic [3:0] hist;   // insere as sampled at the last four edges, [0] newest

  function automatic int lock_len(input int k);
    return (k == 0) ? 8 : 0;
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = M_ENTRY; m_pos[k] = 0; m_errs[k] = 0; m_left[k] = 0;
      m_shown[k] = -1; m_plen[k] = 0; m_done[k] = 0;
      for (int i = 0; i < N_DIG; i++) m_code[k][i] = ref_code[i];
    end
  endtask

  task automatic model_edge(input bit stb);
    int d;
    d = int'(numero);
    for (int k = 0; k < 2; k++) begin
      m_done[k] = 0;
      case (m_mode[k])
        M_LOCK: begin
          if (lock_len(k) > 0) begin
            m_left[k]--;
            if (m_left[k] == 0) m_mode[k] = M_ENTRY;
          end
        end
        M_ENTRY: begin
          if (stb) begin
            m_shown[k] = d;
            if (d <= 9 && d == m_code[k][m_pos[k]]) begin
              m_pos[k]++;
              if (m_pos[k] == N_DIG) begin
                m_mode[k] = M_OPEN; m_pos[k] = 0; m_errs[k] = 0;
              end
            end else begin
              m_errs[k]++;
              if (m_errs[k] == N_ERR) begin
                m_mode[k] = M_LOCK; m_left[k] = lock_len(k); m_pos[k] = 0; m_errs[k] = 0;
              end
            end
          end
        end
        default: begin
          if (relock) begin
            m_mode[k] = M_ENTRY; m_plen[k] = 0;
          end else if (!prog_en) begin
            m_plen[k] = 0;
          end else if (stb && d <= 9) begin
            m_pbuf[k][m_plen[k]] = d;
            m_plen[k]++;
            if (m_plen[k] == N_DIG) begin
              for (int i = 0; i < N_DIG; i++) m_code[k][i] = m_pbuf[k][i];
              m_done[k] = 1; m_plen[k] = 0;
            end
          end
        end
      endcase
    end
  endtask

  function automatic logic [31:0] expect_out(input int k);
    logic       u, w, l;
    logic [6:0] s;
    u = (m_mode[k] == M_OPEN);
    l = (m_mode[k] == M_LOCK);
    w = (m_mode[k] == M_ENTRY) && (m_errs[k] > 0);
    case (m_mode[k])
      M_ENTRY: s = (m_shown[k] < 0) ? 7'h7F : seg_of(m_shown[k]);
      M_OPEN:  s = (m_plen[k] > 0) ? seg_of(m_pbuf[k][m_plen[k]-1]) : 7'h41;
      default: s = 7'h06;
    endcase
    return {18'd0, u, w, l, m_done[k], 3'(m_pos[k]), s};
  endfunction

  // One clock: model advances on the edge, both DUTs compared on the falling edge
  task automatic step();
    bit stb_now;
    @(posedge clk);
    cyc++;
    if (reset) begin
      model_reset();
      hist = 4'b0;
    end else begin
      stb_now = hist[2] & ~hist[3];
      hist = {hist[2:0], insere};
      model_edge(stb_now);
    end
    @(negedge clk);
    check_eq($sformatf("cyc%0d_dut0", cyc),
             {18'd0, unlocked0, warn0, locked_out0, prog_done0, digit_idx0, seg0}, expect_out(0));
    check_eq($sformatf("cyc%0d_dut1", cyc),
             {18'd0, unlocked1, warn1, locked_out1, prog_done1, digit_idx1, seg1}, expect_out(1));
    if (locked_out0) lo_count++;
    if (prog_done0)  pd_count++;
  endtask

  task automatic press(input int d, input int hold = 4, input int low = 4);
    numero = 4'(d);
    insere = 1'b1;
    repeat (hold) step();
    insere = 1'b0;
    repeat (low) step();
  endtask

  task automatic enter_code(input int c0, c1, c2, c3, c4, c5);
    press(c0); press(c1); press(c2); press(c3); press(c4); press(c5);
  endtask

  task automatic do_reset(input int n = 1);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
  endtask

  task automatic do_relock();
    relock = 1'b1;
    step();
    relock = 1'b0;
  endtask

  initial begin
    int r, d;
    reset = 1'b1; insere = 1'b0; numero = 4'd0; relock = 1'b0; prog_en = 1'b0;
    hist = 4'b0;
    model_reset();
    do_reset(2);
    check_eq("reset_outputs", {unlocked0, warn0, locked_out0, prog_done0, digit_idx0, seg0},
             {4'b0000, 3'd0, 7'h7F});

    // Correct code opens the lock
    enter_code(5, 9, 0, 2, 8, 1);
    check_eq("open_unlocked", unlocked0, 1);
    check_eq("open_seg", seg0, 7'h41);
    check_eq("open_warn", warn0, 0);

    // One wrong digit raises warn and retries the same position
    do_relock();
    press(5); press(3);
    check_eq("warn_after_3", warn0, 1);
    check_eq("idx_held", digit_idx0, 1);
    press(9); press(0); press(2); press(8); press(1);
    check_eq("open_after_retry", unlocked0, 1);

    // A held insere yields one digit; reset mid-entry clears everything
    do_relock();
    press(5, 50, 4);
    check_eq("long_hold_one_digit", digit_idx0, 1);
    press(9);
    do_reset();
    check_eq("reset_mid_entry", {unlocked0, warn0, locked_out0, prog_done0, digit_idx0, seg0},
             {4'b0000, 3'd0, 7'h7F});

    // Reprogram to 123456, old code then fails, new one opens
    enter_code(5, 9, 0, 2, 8, 1);
    prog_en = 1'b1;
    pd_count = 0;
    enter_code(1, 2, 3, 4, 5, 6);
    check_eq("prog_done_once", pd_count, 1);
    check_eq("open_after_prog", unlocked0, 1);
    prog_en = 1'b0;
    step();
    do_relock();
    press(5); press(9);
    check_eq("old_code_locks", locked_out0, 1);
    repeat (12) step();
    enter_code(1, 2, 3, 4, 5, 6);
    check_eq("new_code_opens", unlocked0, 1);

    // Timed lockout lasts exactly 8 cycles and ignores strobes
    do_reset();
    press(5); press(3);
    lo_count = 0;
    press(7, 4, 3);
    press(1, 3, 3);
    repeat (20) step();
    check_eq("lockout_len", lo_count, 8);
    check_eq("after_lockout", {warn0, locked_out0, digit_idx0}, 5'd0);

    // Zero-length lockout only leaves on reset
    repeat (1000) step();
    check_eq("perm_lockout_held", locked_out1, 1);
    do_reset();
    check_eq("perm_lockout_reset", {unlocked1, warn1, locked_out1, prog_done1, digit_idx1, seg1},
             {4'b0000, 3'd0, 7'h7F});

    // Randomised traffic; every cycle is compared against the model
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        do_reset();
      end else if (r < 10) begin
        do_relock();
      end else if (r < 18) begin
        prog_en = ~prog_en;
        step();
      end else if (r < 22) begin
        repeat ($urandom_range(1, 10)) step();
      end else begin
        if ($urandom_range(0, 2) != 0 && m_mode[0] == M_ENTRY) d = m_code[0][m_pos[0]];
        else d = $urandom_range(0, 11);
        press(d, $urandom_range(3, 6), $urandom_range(3, 5));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
